sawtooth_duty_decoder: RTL and testbench
========================================

Name: sawtooth_duty_decoder

Overview:
- Receive-side counterpart of the sawtooth waveform generator. It consumes a framed stream of signed 16-bit sawtooth samples, one frame per waveform period.
- For each frame it measures the ramp length and recovers the 0..10 duty selector that produced it.
- Flags malformed frames and asserts lock once two consecutive good frames agree.
- Sits after the waveform source / FIR-IIR path in loopback and self-test configurations.

Parameters:
- DATA_W, 16, sample width (signed).
- PERIOD, 1024, samples per frame (generator memory size).
- CNT_W, 11, counter width; must satisfy 2**CNT_W > PERIOD.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  sample strobe; i_data and i_sof are sampled only when high.
- i_sof  in  1  start of frame; marks the address-0 sample.
- i_data  in  DATA_W  signed sample.
- o_valid  out  1  one-cycle pulse; result fields are valid.
- o_sel  out  4  decoded duty selector, 0..10.
- o_ramp_len  out  CNT_W  measured ramp length (peak position).
- o_err  out  1  frame malformed; qualified by o_valid.
- o_locked  out  1  level; two consecutive error-free frames with equal o_sel.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - All outputs go to 0; the FSM goes to IDLE; counters and the pipeline are cleared.
  - A frame in progress is discarded and no o_valid is produced for it.
- Frame-capture FSM. It advances only on cycles with i_valid=1; i_valid=0 holds all state (bubbles are allowed).
  - IDLE: a sample with i_sof=1 goes to RAMP with idx=1. If that first sample is nonzero, set the frame error flag. Samples without i_sof are ignored.
  - RAMP: a sample >0 that is >= the previous sample gives nz++.
    - A sample ==0 goes to FLAT.
    - A sample <0, or one smaller than the previous sample, sets the error flag.
  - FLAT: any nonzero sample sets the error flag (non-contiguous ramp).
- Frame end:
  - The frame ends on the sample with idx==PERIOD-1. Latch nz and the error flag into pipeline stage 1, then go to IDLE.
  - The next i_sof may arrive in the very next cycle. Back-to-back frames are supported with no dead cycle.
- Early sof: i_sof=1 in RAMP/FLAT aborts the current frame.
  - Push the aborted frame to stage 1 with the error flag set.
  - That same sample starts a new frame.
- Late or missing sof: after a frame ends, samples are ignored in IDLE until the next i_sof.
- Decode, stage 1 to stage 2:
  - ramp_len = (nz==0) ? 0 : nz+1.
  - Compare ramp_len against the table PEAK[s] = floor(PERIOD*s/10), s=0..10, using constants only (no divider).
  - An exact match gives sel=s.
  - No match gives sel = largest s with PEAK[s] < ramp_len, and err=1.
- Output, stage 2:
  - Registered; o_valid pulses exactly 2 cycles after the last frame sample is accepted (sample at edge N, o_valid high in cycle N+2).
  - o_sel, o_ramp_len and o_err update with o_valid and hold until the next pulse.
- Lock:
  - o_locked sets on an error-free result whose sel equals the previous error-free result's sel.
  - It clears on any err result or a sel mismatch.
  - The first result after reset never sets lock.
- Simultaneous events: if a frame-end sample is also the cycle a previous result is in stage 2, both complete; the pipeline is fully pipelined, one result per frame.
- Widths:
  - nz and idx are CNT_W unsigned.
  - Sample comparisons are signed DATA_W.
  - No arithmetic exceeds CNT_W+1 bits.

Decomposition:
- Package sawtooth_pkg holds PERIOD, DATA_W, MAX_VAL (16'h1FFF), SEL_MAX (10), the PEAK table function or constant array, and the FSM state enum (IDLE, RAMP, FLAT).
- Optional sub-module sawtooth_peak_lut: a combinational ramp_len-to-{sel, match} lookup, shared with the generator-side tests.

Test Plan:
- Drive a generator-shaped frame for sel=3 (peak 307): o_valid pulses once; o_sel=3, o_ramp_len=307, o_err=0.
- Drive sel=0 (all zeros) → o_sel=0, o_ramp_len=0, o_err=0. Drive sel=10 (ramp over all 1024 samples, no zero) → o_sel=10, o_ramp_len=1024.
- Send sel=5 twice back-to-back with random i_valid bubbles (~30%) → o_locked=0 after the first result and 1 after the second; results are independent of bubbles.
- Send i_sof again at idx 500 of a sel=7 frame → err result with o_err=1, o_locked cleared; the new frame decodes correctly.
- Inject a decrease (sample 200 < sample 199) in a sel=4 frame, and separately a nonzero sample at idx 900 in a sel=2 frame → both give o_err=1.
- Assert i_rst at idx 600 of a frame → outputs 0, no o_valid; the next clean sel=6 frame decodes to o_sel=6 (peak 614).

Source files
------------

// File: rtl/sawtooth_pkg.sv
// rtl/sawtooth_pkg.sv - shared constants, PEAK table helper and FSM states for the sawtooth decoder
package sawtooth_pkg;

    localparam int DATA_W  = 16;
    localparam int PERIOD  = 1024;
    localparam int CNT_W   = 11;
    localparam logic [DATA_W-1:0] MAX_VAL = 16'h1FFF;
    localparam int SEL_MAX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        FLAT = 2'd2
    } state_t;

    // Peak position for duty selector s; only ever called with elaboration-time constants
    function automatic int peak_of(input int period, input int s);
        return (period * s) / 10;
    endfunction

endpackage

// File: rtl/sawtooth_peak_lut.sv
// rtl/sawtooth_peak_lut.sv - combinational ramp length to duty selector lookup
module sawtooth_peak_lut
    import sawtooth_pkg::*;
#(
    parameter int PERIOD = sawtooth_pkg::PERIOD,
    parameter int CNT_W  = sawtooth_pkg::CNT_W
) (
    input  logic [CNT_W-1:0] ramp_len,
    output logic [3:0]       sel,
    output logic             hit
);

    // Ascending scan: an exact peak wins, otherwise the last peak below ramp_len is kept
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int s = 0; s <= SEL_MAX; s++) begin
            if (ramp_len == CNT_W'(peak_of(PERIOD, s))) begin
                sel = 4'(s);
                hit = 1'b1;
            end else if (CNT_W'(peak_of(PERIOD, s)) < ramp_len) begin
                sel = 4'(s);
            end
        end
    end

endmodule

// File: rtl/sawtooth_duty_decoder.sv
// rtl/sawtooth_duty_decoder.sv - measures sawtooth ramp length per frame and recovers the duty selector
module sawtooth_duty_decoder
    import sawtooth_pkg::*;
#(
    parameter int DATA_W = sawtooth_pkg::DATA_W,
    parameter int PERIOD = sawtooth_pkg::PERIOD,
    parameter int CNT_W  = sawtooth_pkg::CNT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_valid,
    output logic [3:0]               o_sel,
    output logic [CNT_W-1:0]         o_ramp_len,
    output logic                     o_err,
    output logic                     o_locked
);

    state_t state, state_n;

    logic [CNT_W-1:0]         idx, idx_n;
    logic [CNT_W-1:0]         nz, nz_n, upd_nz;
    logic                     err, err_n, upd_err;
    logic signed [DATA_W-1:0] prev;

    logic                     push;
    logic [CNT_W-1:0]         push_nz;
    logic                     push_err;

    logic                     s1_valid;
    logic [CNT_W-1:0]         s1_nz;
    logic                     s1_err;

    logic [CNT_W-1:0]         ramp_len;
    logic [3:0]               lut_sel;
    logic                     lut_hit;
    logic                     res_err;

    logic                     ref_valid;
    logic [3:0]               ref_sel;

    logic data_zero, data_neg, data_pos, last_sample;

    assign data_zero   = (i_data == '0);
    assign data_neg    = i_data[DATA_W-1];
    assign data_pos    = !data_zero && !data_neg;
    assign last_sample = (idx == CNT_W'(PERIOD - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: only accepted samples move the FSM; an sof in a frame restarts it
    always_comb begin
        state_n = state;
        if (i_valid) begin
            unique case (state)
                IDLE: if (i_sof) state_n = RAMP;
                RAMP, FLAT: begin
                    if (i_sof)                           state_n = RAMP;
                    else if (last_sample)                state_n = IDLE;
                    else if (state == RAMP && data_zero) state_n = FLAT;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame bookkeeping: per-sample nz/error update and stage-1 push on frame end or abort
    always_comb begin
        idx_n    = idx;
        nz_n     = nz;
        err_n    = err;
        upd_nz   = nz;
        upd_err  = err;
        push     = 1'b0;
        push_nz  = nz;
        push_err = err;
        if (state == RAMP) begin
            if (data_pos && i_data >= prev) upd_nz  = nz + CNT_W'(1);
            else if (!data_zero)            upd_err = 1'b1;
        end else if (state == FLAT) begin
            if (!data_zero) upd_err = 1'b1;
        end
        if (i_valid) begin
            if (i_sof) begin
                if (state != IDLE) begin
                    push     = 1'b1;
                    push_nz  = nz;
                    push_err = 1'b1;
                end
                idx_n = CNT_W'(1);
                nz_n  = '0;
                err_n = !data_zero;
            end else if (state != IDLE) begin
                if (last_sample) begin
                    push     = 1'b1;
                    push_nz  = upd_nz;
                    push_err = upd_err;
                end else begin
                    idx_n = idx + CNT_W'(1);
                    nz_n  = upd_nz;
                    err_n = upd_err;
                end
            end
        end
    end

    // Frame counters and previous-sample register, held across bubbles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx  <= '0;
            nz   <= '0;
            err  <= 1'b0;
            prev <= '0;
        end else if (i_valid) begin
            idx  <= idx_n;
            nz   <= nz_n;
            err  <= err_n;
            prev <= i_data;
        end
    end

    // Stage 1: latch the finished or aborted frame summary
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_nz    <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= push;
            if (push) begin
                s1_nz  <= push_nz;
                s1_err <= push_err;
            end
        end
    end

    assign ramp_len = (s1_nz == '0) ? '0 : s1_nz + CNT_W'(1);
    assign res_err  = s1_err || !lut_hit;

    sawtooth_peak_lut #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_lut (
        .ramp_len (ramp_len),
        .sel      (lut_sel),
        .hit      (lut_hit)
    );

    // Stage 2: registered result and lock tracking against the last error-free selector
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_sel      <= '0;
            o_ramp_len <= '0;
            o_err      <= 1'b0;
            o_locked   <= 1'b0;
            ref_valid  <= 1'b0;
            ref_sel    <= '0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_sel      <= lut_sel;
                o_ramp_len <= ramp_len;
                o_err      <= res_err;
                if (res_err) begin
                    o_locked  <= 1'b0;
                    ref_valid <= 1'b0;
                end else begin
                    o_locked  <= ref_valid && (ref_sel == lut_sel);
                    ref_valid <= 1'b1;
                    ref_sel   <= lut_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_sawtooth_duty_decoder.sv
// tb/tb_sawtooth_duty_decoder.sv - scoreboard bench for sawtooth_duty_decoder
module tb_sawtooth_duty_decoder;

    typedef struct {
        int sel;
        int len;
        int err;
        int lock;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid = 1'b0;
    logic               sof = 1'b0;
    logic signed [15:0] data = '0;
    logic               o_valid;
    logic [3:0]         o_sel;
    logic [10:0]        o_ramp_len;
    logic               o_err;
    logic               o_locked;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   frm [0:1023];
    exp_t sb [$];
    bit   ref_ok = 0;
    int   ref_sel = 0;
    exp_t pend;
    bit   pend_ok = 0;

    sawtooth_duty_decoder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_sof      (sof),
        .i_data     (data),
        .o_valid    (o_valid),
        .o_sel      (o_sel),
        .o_ramp_len (o_ramp_len),
        .o_err      (o_err),
        .o_locked   (o_locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int peak(input int s);
        return (1024 * s) / 10;
    endfunction

    task automatic build(input int s);
        for (int i = 0; i < 1024; i++) frm[i] = (i > 0 && i < peak(s)) ? i : 0;
    endtask

    function automatic exp_t evaluate(input int n, input bit force_err);
        exp_t e;
        int nz, prv, cand;
        bit in_ramp, er;
        nz = 0;
        er = (frm[0] != 0);
        prv = frm[0];
        in_ramp = 1;
        for (int i = 1; i < n; i++) begin
            if (in_ramp) begin
                if (frm[i] == 0) in_ramp = 0;
                else if (frm[i] > 0 && frm[i] >= prv) nz++;
                else er = 1;
            end else if (frm[i] != 0) begin
                er = 1;
            end
            prv = frm[i];
        end
        e.len = (nz == 0) ? 0 : nz + 1;
        cand = (10 * e.len + 1023) / 1024;
        if (cand <= 10 && peak(cand) == e.len) begin
            e.sel = cand;
        end else begin
            e.sel = (cand > 10) ? 10 : cand - 1;
            er = 1;
        end
        e.err = (er || force_err) ? 1 : 0;
        e.lock = 0;
        e.cyc = 0;
        return e;
    endfunction

    task automatic push_result(input exp_t e, input int c);
        exp_t x;
        x = e;
        x.cyc = c;
        if (x.err != 0) begin
            x.lock = 0;
            ref_ok = 0;
        end else begin
            x.lock = (ref_ok && ref_sel == x.sel) ? 1 : 0;
            ref_ok = 1;
            ref_sel = x.sel;
        end
        sb.push_back(x);
    endtask

    task automatic drive_frame(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < pct) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
            valid = 1'b1;
            sof = (i == 0);
            data = 16'(frm[i]);
            @(posedge clk); #1;
            if (i == 0 && pend_ok) begin
                push_result(pend, cyc + 1);
                pend_ok = 0;
            end
            if (i == n - 1 && n == 1024) push_result(evaluate(1024, 0), cyc + 1);
        end
        valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    // Result monitor: pops one expectation per o_valid pulse
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cyc=%0d sel=%0d len=%0d", cyc, o_sel, o_ramp_len);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
                end
                checks++;
                if (int'(o_sel) !== e.sel) begin
                    errors++;
                    $display("FAIL sel got=%0d want=%0d", o_sel, e.sel);
                end
                checks++;
                if (int'(o_ramp_len) !== e.len) begin
                    errors++;
                    $display("FAIL ramp_len got=%0d want=%0d", o_ramp_len, e.len);
                end
                checks++;
                if (int'(o_err) !== e.err) begin
                    errors++;
                    $display("FAIL err got=%0d want=%0d", o_err, e.err);
                end
                checks++;
                if (int'(o_locked) !== e.lock) begin
                    errors++;
                    $display("FAIL locked got=%0d want=%0d", o_locked, e.lock);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({o_valid, o_sel, o_ramp_len, o_err, o_locked} !== '0) begin
            errors++;
            $display("FAIL %s got v=%0d sel=%0d len=%0d err=%0d lock=%0d want all 0",
                     name, o_valid, o_sel, o_ramp_len, o_err, o_locked);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset_outputs");
    endtask

    task automatic test_sel3();
        build(3);
        drive_frame(1024, 0);
        drain("sel3");
    endtask

    task automatic test_extremes();
        build(0);
        drive_frame(1024, 0);
        build(10);
        drive_frame(1024, 0);
        drain("sel0_sel10");
    endtask

    task automatic test_back_to_back();
        build(5);
        drive_frame(1024, 30);
        drive_frame(1024, 30);
        drain("back_to_back_sel5");
    endtask

    task automatic test_early_sof();
        build(7);
        drive_frame(500, 0);
        pend = evaluate(500, 1);
        pend_ok = 1;
        build(7);
        drive_frame(1024, 10);
        drain("early_sof");
    endtask

    task automatic test_malformed();
        build(4);
        frm[200] = frm[199] - 1;
        drive_frame(1024, 0);
        build(2);
        frm[900] = 5;
        drive_frame(1024, 0);
        drain("malformed");
    endtask

    task automatic test_late_sof();
        valid = 1'b1;
        sof = 1'b0;
        data = 16'sd7;
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b0;
        build(1);
        drive_frame(1024, 0);
        drain("late_sof_sel1");
    endtask

    task automatic test_reset_midframe();
        build(8);
        drive_frame(600, 0);
        valid = 1'b1;
        sof = 1'b0;
        data = 16'(frm[600]);
        rst = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        rst = 1'b0;
        ref_ok = 0;
        pend_ok = 0;
        check_idle_outputs("midframe_reset_outputs");
        repeat (6) @(posedge clk);
        #1;
        check_idle_outputs("midframe_reset_quiet");
        build(6);
        drive_frame(1024, 0);
        drain("post_reset_sel6");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sel3();
        test_extremes();
        test_back_to_back();
        test_early_sof();
        test_malformed();
        test_late_sof();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
